// File: rtl/gray_matrix_3x3_gen_if.sv
// Pixel stream in / 3x3 window stream out for gray_matrix_3x3_gen.
// master = pixel source side, slave = the window generator.
interface gray_matrix_3x3_gen_if;
  logic       per_img_vsync;
  logic       per_img_href;
  logic [7:0] per_img_gray;
  logic       matrix_img_vsync;
  logic       matrix_img_href;
  logic [7:0] matrix_p11, matrix_p12, matrix_p13;
  logic [7:0] matrix_p21, matrix_p22, matrix_p23;
  logic [7:0] matrix_p31, matrix_p32, matrix_p33;

  modport master (
    output per_img_vsync, per_img_href, per_img_gray,
    input  matrix_img_vsync, matrix_img_href,
    input  matrix_p11, matrix_p12, matrix_p13,
    input  matrix_p21, matrix_p22, matrix_p23,
    input  matrix_p31, matrix_p32, matrix_p33
  );

  modport slave (
    input  per_img_vsync, per_img_href, per_img_gray,
    output matrix_img_vsync, matrix_img_href,
    output matrix_p11, matrix_p12, matrix_p13,
    output matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33
  );
endinterface

// File: rtl/gray_matrix_3x3_gen.sv
// Streaming 3x3 neighbourhood generator, 8-bit gray, 2-clock latency.
// Two line buffers (A = row r-1, B = row r-2) plus a column shift register.
// Build option MATRIX_EDGE_REPLICATE_EN: out-of-image taps replicate the
// nearest in-image pixel; when undefined they read 0x00.
module gray_matrix_3x3_gen #(
  parameter int IMG_H_DISP = 640,
  parameter int IMG_V_DISP = 480
) (
  input logic                  clk,
  input logic                  rst_n,
  gray_matrix_3x3_gen_if.slave bus
);
  localparam int AW = (IMG_H_DISP > 1) ? $clog2(IMG_H_DISP) : 1;
  localparam int CW = $clog2(IMG_H_DISP + 1);
  localparam int RW = (IMG_V_DISP > 1) ? $clog2(IMG_V_DISP) : 1;
  localparam logic [CW-1:0] COL_END  = CW'(IMG_H_DISP);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_V_DISP - 1);

  // one column of the window: [0] = row r-2, [1] = row r-1, [2] = row r
  typedef logic [2:0][7:0] col_t;

  logic          vsync, href;
  logic [7:0]    gray;
  logic          vs_d1, vs_d2, hr_d1, hr_d2;
  logic [CW-1:0] col_cnt, col_idx;
  logic [RW-1:0] row_cnt;
  logic          ovl, wr_en;
  logic [AW-1:0] addr;

  assign vsync = bus.per_img_vsync;
  assign href  = bus.per_img_href;
  assign gray  = bus.per_img_gray;

  // column of the pixel being sampled now; first pixel of a line is column 0
  assign col_idx = (href && !hr_d1) ? '0 : col_cnt;
  // col_cnt parks at IMG_H_DISP once a line overruns, flagging extra pixels
  assign ovl     = (col_idx >= COL_END);
  assign wr_en   = href && !ovl;
  assign addr    = col_idx[AW-1:0];

  // sync delay line and column/row counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d1   <= 1'b0;
      vs_d2   <= 1'b0;
      hr_d1   <= 1'b0;
      hr_d2   <= 1'b0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      vs_d1 <= vsync;
      vs_d2 <= vs_d1;
      hr_d1 <= href;
      hr_d2 <= hr_d1;
      if (href) col_cnt <= ovl ? col_idx : col_idx + 1'b1;
      if (!vsync)
        row_cnt <= '0;
      else if (hr_d1 && !href && row_cnt != ROW_LAST)
        row_cnt <= row_cnt + 1'b1;
    end
  end

  logic [7:0] ram_a [IMG_H_DISP];
  logic [7:0] ram_b [IMG_H_DISP];
  logic [7:0] s1_a, s1_b;

  // line buffers: read-before-write, row r-1 drops down into the r-2 buffer
  always_ff @(posedge clk) begin
    if (wr_en) begin
      s1_a        <= ram_a[addr];
      s1_b        <= ram_b[addr];
      ram_a[addr] <= gray;
      ram_b[addr] <= ram_a[addr];
    end
  end

  logic [7:0] s1_g;
  logic       s1_r0, s1_r1, s1_c0, s1_c1, s1_ovl;

  // stage 1: current pixel and the edge position it was sampled at
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_g   <= '0;
      s1_r0  <= 1'b0;
      s1_r1  <= 1'b0;
      s1_c0  <= 1'b0;
      s1_c1  <= 1'b0;
      s1_ovl <= 1'b0;
    end else if (href) begin
      s1_g   <= gray;
      s1_r0  <= (row_cnt == '0);
      s1_r1  <= (row_cnt == RW'(1));
      s1_c0  <= (col_idx == '0);
      s1_c1  <= (col_idx == CW'(1));
      s1_ovl <= ovl;
    end
  end

  col_t s1_col, sh_c1, sh_c2;
  logic [2:0][2:0][7:0] win, win_q;   // [row][tap], tap 0 = c-2, tap 2 = c

  assign s1_col = {s1_g, s1_a, s1_b};

  // assemble the window and fill out-of-image taps; stale data never leaks
  always_comb begin
    win = '0;
    for (int k = 0; k < 3; k++) begin
      win[k][2] = s1_col[k];
`ifdef MATRIX_EDGE_REPLICATE_EN
      win[k][1] = s1_c0 ? s1_col[k] : sh_c1[k];
      win[k][0] = (s1_c0 || s1_c1) ? win[k][1] : sh_c2[k];
`else
      win[k][1] = s1_c0 ? 8'h00 : sh_c1[k];
      win[k][0] = (s1_c0 || s1_c1) ? 8'h00 : sh_c2[k];
`endif
    end
`ifdef MATRIX_EDGE_REPLICATE_EN
    if (s1_r0 || s1_ovl)          win[1] = win[2];
    if (s1_r0 || s1_r1 || s1_ovl) win[0] = win[1];
`else
    if (s1_r0 || s1_ovl)          win[1] = '0;
    if (s1_r0 || s1_r1 || s1_ovl) win[0] = '0;
`endif
  end

  // stage 2: shift raw columns and register the window; holds while href=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_c1 <= '0;
      sh_c2 <= '0;
      win_q <= '0;
    end else if (hr_d1) begin
      sh_c2 <= sh_c1;
      sh_c1 <= s1_col;
      win_q <= win;
    end
  end

  assign bus.matrix_img_vsync = vs_d2;
  assign bus.matrix_img_href  = hr_d2;
  assign bus.matrix_p11 = win_q[0][0];
  assign bus.matrix_p12 = win_q[0][1];
  assign bus.matrix_p13 = win_q[0][2];
  assign bus.matrix_p21 = win_q[1][0];
  assign bus.matrix_p22 = win_q[1][1];
  assign bus.matrix_p23 = win_q[1][2];
  assign bus.matrix_p31 = win_q[2][0];
  assign bus.matrix_p32 = win_q[2][1];
  assign bus.matrix_p33 = win_q[2][2];
endmodule

// File: tb/tb_gray_matrix_3x3_gen.sv
// Bench for gray_matrix_3x3_gen: windows predicted from a stored frame,
// queued at drive time and compared when matrix_img_href rises out.
module tb_gray_matrix_3x3_gen;
  localparam int H = 8;
  localparam int V = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gray_matrix_3x3_gen_if bus ();

  gray_matrix_3x3_gen #(.IMG_H_DISP(H), .IMG_V_DISP(V)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          href_cnt = 0;
  int          vs_cnt = 0;
  logic [7:0]  img [0:7][0:15];
  int          lens [0:7];
  logic [71:0] sb [$];
  logic [1:0]  d1, d2;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] win_now();
    return {bus.matrix_p11, bus.matrix_p12, bus.matrix_p13,
            bus.matrix_p21, bus.matrix_p22, bus.matrix_p23,
            bus.matrix_p31, bus.matrix_p32, bus.matrix_p33};
  endfunction

  function automatic logic [79:0] outs_now();
    return {6'd0, bus.matrix_img_vsync, bus.matrix_img_href, win_now()};
  endfunction

  // expected window for the pixel at line r, column c of the current frame
  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    logic [7:0]  v;
    int          rr, cc;
    w = '0;
    for (int dr = 2; dr >= 0; dr--) begin
      for (int dc = 2; dc >= 0; dc--) begin
`ifdef MATRIX_EDGE_REPLICATE_EN
        rr = (c >= H) ? r : ((r - dr < 0) ? 0 : r - dr);
        cc = (c - dc < 0) ? 0 : c - dc;
        v  = img[rr][cc];
`else
        rr = r - dr;
        cc = c - dc;
        if (rr >= 0 && cc >= 0 && !(c >= H && dr > 0)) v = img[rr][cc];
        else v = 8'h00;
`endif
        w = {w[63:0], v};
      end
    end
    return w;
  endfunction

  // input history, to check the 2-cycle sync delay
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= 2'b00;
      d2 <= 2'b00;
    end else begin
      d1 <= {bus.per_img_vsync, bus.per_img_href};
      d2 <= d1;
    end
  end

  // output monitor: sync alignment every cycle, window compare on href
  always @(negedge clk) begin
    if (rst_n) begin
      chk("sync", {78'd0, bus.matrix_img_vsync, bus.matrix_img_href}, {78'd0, d2});
      if (bus.matrix_img_vsync) vs_cnt++;
      if (bus.matrix_img_href) begin
        href_cnt++;
        chk("sb_nonempty", 80'(sb.size() != 0), 80'd1);
        if (sb.size() != 0) chk("win", {8'd0, win_now()}, {8'd0, sb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input int r, input int c);
    bus.per_img_href = 1'b1;
    bus.per_img_gray = img[r][c];
    sb.push_back(exp_win(r, c));
    tick();
  endtask

  task automatic send_frame(input int nl, input int gap_max);
    bus.per_img_vsync = 1'b1;
    repeat (3) tick();
    for (int r = 0; r < nl; r++) begin
      for (int c = 0; c < lens[r]; c++) send_px(r, c);
      bus.per_img_href = 1'b0;
      repeat ($urandom_range(gap_max, 1)) tick();
    end
    bus.per_img_vsync = 1'b0;
    repeat (4) tick();
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 8; r++) begin
      lens[r] = H;
      for (int c = 0; c < 16; c++) img[r][c] = 8'(r * 16 + c);
    end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 8; r++) begin
      lens[r] = H;
      for (int c = 0; c < 16; c++) img[r][c] = 8'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.per_img_vsync = 1'b0;
    bus.per_img_href  = 1'b0;
    bus.per_img_gray  = 8'h00;

    // held reset with random inputs: everything stays zero
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.per_img_vsync = 1'($urandom);
      bus.per_img_href  = 1'($urandom);
      bus.per_img_gray  = 8'($urandom);
      #1 chk("rst_hold", outs_now(), 80'd0);
    end
    bus.per_img_vsync = 1'b0;
    bus.per_img_href  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ramp frame, pixel = row*16 + col
    fill_ramp();
    send_frame(V, 3);

    // random frame, one line past the row limit
    fill_rand();
    send_frame(5, 4);

    // overlong second line (10 pixels into an 8-deep buffer)
    fill_rand();
    lens[1] = 10;
    send_frame(4, 2);

    // sync shape: 50-cycle vsync window carrying one 8-pixel line
    fill_rand();
    href_cnt = 0;
    vs_cnt = 0;
    bus.per_img_vsync = 1'b1;
    repeat (10) tick();
    for (int c = 0; c < H; c++) send_px(0, c);
    bus.per_img_href = 1'b0;
    repeat (32) tick();
    bus.per_img_vsync = 1'b0;
    repeat (5) tick();
    chk("href_len", 80'(href_cnt), 80'd8);
    chk("vsync_len", 80'(vs_cnt), 80'd50);

    // asynchronous reset in the middle of a line
    fill_rand();
    bus.per_img_vsync = 1'b1;
    repeat (2) tick();
    for (int c = 0; c < H; c++) send_px(0, c);
    bus.per_img_href = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) send_px(1, c);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", outs_now(), 80'd0);
    bus.per_img_href  = 1'b0;
    bus.per_img_vsync = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // first frame after reset: stale line buffers must stay masked
    fill_ramp();
    send_frame(V, 2);

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("sb_drain", 80'(sb.size()), 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
